biquad_filter: RTL
==================

Name: biquad_filter

Overview:
- Direct Form I second-order IIR section.
- Sits directly downstream of coefficient_unit: latches its b0/b1/b2/a1/a2 outputs (Q8.16) when that unit signals ready.
- Filters a stream of signed 24-bit samples using one shared multiplier, iterated over five MAC cycles per sample.
- Difference equation: y[n] = b0·x[n] + b1·x[n-1] + b2·x[n-2] − a1·y[n-1] − a2·y[n-2].

Parameters:
- SAMPLE_WIDTH, 24, width of samples and coefficients.
- FRAC_BITS, 16, fractional bits of the Q-format coefficients.
- ACC_WIDTH, 52, accumulator width; must be ≥ 2·SAMPLE_WIDTH+3.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- coef_load  in  1  one-cycle strobe; connect to coefficient_unit ready.
- b0, b1, b2, a1, a2  in  SAMPLE_WIDTH each  signed Q8.16 coefficients.
- in_valid  in  1  in_sample is valid.
- in_sample  in  SAMPLE_WIDTH  signed input sample.
- in_ready  out  1  block can accept a sample.
- out_valid  out  1  one-cycle pulse; out_sample is valid.
- out_sample  out  SAMPLE_WIDTH  signed filtered sample.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values:
  - out_valid=0, out_sample=0.
  - x1, x2, y1, y2 history = 0.
  - Active coefficients = passthrough: b0=65536, all others 0.
  - Pending-coefficient flag cleared.
  - in_ready=0 while reset is high.
- FSM states: IDLE, MAC, OUT.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch x=in_sample, preload acc=2^(FRAC_BITS-1) (round-half-up), set idx=0, go to MAC.
  - MAC: one product per cycle, order idx 0..4 = b0·x, b1·x1, b2·x2, −a1·y1, −a2·y2. Each product is 2·SAMPLE_WIDTH bits, sign-extended to ACC_WIDTH and added. After idx=4, go to OUT.
  - OUT: result = acc >>> FRAC_BITS, reduced to SAMPLE_WIDTH. Register out_sample and pulse out_valid for exactly one cycle. Shift history: x2←x1, x1←x, y2←y1, y1←result. Go to IDLE.
- Latency and throughput:
  - out_valid is high in the 6th cycle after the accept edge (5 MAC cycles + 1 output cycle).
  - in_ready returns high the following cycle.
  - Throughput: 1 sample per 7 cycles.
- Backpressure: none on the output. in_valid held while busy is ignored and not queued; the upstream source holds it until in_ready.
- y history stores the reduced result, i.e. saturated or wrapped per BIQUAD_SAT_EN.
- Coefficient load rules:
  - coef_load in IDLE: coefficients are latched into the active registers immediately.
  - coef_load together with a sample accept in the same IDLE cycle: the accepted sample uses the new coefficients.
  - coef_load during MAC/OUT: coefficients go to shadow registers and a pending flag is set. They are applied on the OUT→IDLE edge, so the in-flight sample uses the old set.
  - A second coef_load while pending overwrites the shadow registers (last one wins).
- History is not cleared on a coefficient change.
- Reset mid-operation: the in-flight sample is abandoned, out_valid is never raised for it, and all registers take their reset values.

Optional Feature:
- Macro: BIQUAD_SAT_EN.
- Defined: the result is clamped to [−2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)−1].
- Undefined: the result is truncated to its low SAMPLE_WIDTH bits (two's-complement wrap).
- Rounding and latency are identical in both cases.

Decomposition:
- Package filter_pkg holds:
  - FRAC_BITS constant.
  - coef_t and sample_t typedefs (signed SAMPLE_WIDTH).
  - coef_set_t struct {b0, b1, b2, a1, a2}.
  - Biquad FSM state enum.
  - Passthrough-reset constant.
- The same package is shared with coefficient_unit.
- Sub-module biquad_mac holds the multiplier, the coefficient/operand select mux on idx, the negation for a-terms, and the accumulator.
- The top level keeps the FSM, history, coefficient shadowing and output reduction.

Test Plan:
- Reset, no coef_load; in_sample=1000 → out_sample=1000, out_valid exactly 6 cycles after accept, in_ready low for 6 cycles.
- coef_load with b0=32768, others 0; in_sample=1001 → out_sample=501 (rounding check).
- b0=65536, a1=−32768, others 0; impulse 1024 then zeros → outputs 1024, 512, 256, 128, 64.
- b0=127·65536, in_sample=100000:
  - with BIQUAD_SAT_EN → 8388607;
  - without it → −4077216.
- Passthrough active; accept sample 200, then coef_load b0=131072 during MAC → first output 200; next sample 200 → 400. Also assert in_valid held during busy is not accepted twice.
- Assert reset during MAC idx=2 → no out_valid; history zero; next sample 50 with passthrough → 50.

Source files
------------

// File: rtl/filter_pkg.sv
// Shared types and constants for the biquad section and the coefficient unit.
package filter_pkg;

    localparam int SAMPLE_W  = 24;
    localparam int FRAC_BITS = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [SAMPLE_W-1:0] coef_t;

    typedef struct packed {
        coef_t b0;
        coef_t b1;
        coef_t b2;
        coef_t a1;
        coef_t a2;
    } coef_set_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_OUT
    } bq_state_t;

    // Unity gain: b0 = 1.0 in Q8.16, everything else zero.
    localparam coef_set_t COEF_PASSTHRU = '{
        b0: coef_t'(1 << FRAC_BITS),
        b1: '0,
        b2: '0,
        a1: '0,
        a2: '0
    };

endpackage

// File: rtl/biquad_mac.sv
// Shared-multiplier MAC for the biquad: one product per cycle, selected by idx.
// idx 0..4 -> b0*x, b1*x1, b2*x2, -a1*y1, -a2*y2. a-terms are negated after
// the multiply so a coefficient of -2^(W-1) cannot overflow the negation.
module biquad_mac
    import filter_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 24,
    parameter int FRAC_BITS    = 16,
    parameter int ACC_WIDTH    = 52
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic                                  step,
    input  logic [2:0]                            idx,
    input  coef_set_t                             coef,
    input  sample_t                               x0,
    input  sample_t                               x1,
    input  sample_t                               x2,
    input  sample_t                               y1,
    input  sample_t                               y2,
    output logic signed [ACC_WIDTH-FRAC_BITS-1:0] acc_int
);

    localparam int PW = 2 * SAMPLE_WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] ACC_RND = ACC_WIDTH'(1) <<< (FRAC_BITS - 1);

    logic signed [SAMPLE_WIDTH-1:0] c_sel;
    logic signed [SAMPLE_WIDTH-1:0] d_sel;
    logic                           neg;
    logic signed [PW-1:0]           prod;
    logic signed [ACC_WIDTH-1:0]    prod_ext;
    logic signed [ACC_WIDTH-1:0]    term;
    logic signed [ACC_WIDTH-1:0]    acc;
    logic signed [ACC_WIDTH-1:0]    acc_next;

    // Coefficient/operand select for the current tap
    always_comb begin
        c_sel = '0;
        d_sel = '0;
        neg   = 1'b0;
        unique case (idx)
            3'd0: begin c_sel = coef.b0; d_sel = x0; end
            3'd1: begin c_sel = coef.b1; d_sel = x1; end
            3'd2: begin c_sel = coef.b2; d_sel = x2; end
            3'd3: begin c_sel = coef.a1; d_sel = y1; neg = 1'b1; end
            3'd4: begin c_sel = coef.a2; d_sel = y2; neg = 1'b1; end
            default: ;
        endcase
    end

    assign prod     = c_sel * d_sel;
    assign prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
    assign term     = neg ? -prod_ext : prod_ext;
    assign acc_next = acc + term;
    assign acc_int  = acc_next[ACC_WIDTH-1:FRAC_BITS];

    // Accumulator: preloaded with half an LSB for round-half-up, then one tap per step
    always_ff @(posedge clk) begin
        if (reset)
            acc <= '0;
        else if (start)
            acc <= ACC_RND;
        else if (step)
            acc <= acc_next;
    end

endmodule

// File: rtl/biquad_filter.sv
// Direct Form I biquad, one shared multiplier, 7 cycles per sample.
// Optional: define BIQUAD_SAT_EN to clamp the output (and y history) instead
// of wrapping it to SAMPLE_WIDTH bits.
module biquad_filter
    import filter_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 24,
    parameter int FRAC_BITS    = 16,
    parameter int ACC_WIDTH    = 52
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           coef_load,
    input  logic signed [SAMPLE_WIDTH-1:0] b0,
    input  logic signed [SAMPLE_WIDTH-1:0] b1,
    input  logic signed [SAMPLE_WIDTH-1:0] b2,
    input  logic signed [SAMPLE_WIDTH-1:0] a1,
    input  logic signed [SAMPLE_WIDTH-1:0] a2,
    input  logic                           in_valid,
    input  logic signed [SAMPLE_WIDTH-1:0] in_sample,
    output logic                           in_ready,
    output logic                           out_valid,
    output logic signed [SAMPLE_WIDTH-1:0] out_sample
);

    localparam int AI = ACC_WIDTH - FRAC_BITS;

    bq_state_t             state, state_nxt;
    logic [2:0]            idx;
    logic                  accept;
    logic                  mac_last;
    coef_set_t             coef_in, coef_act, coef_shd;
    logic                  pend;
    sample_t               x0, x1, x2, y1, y2;
    logic signed [AI-1:0]  acc_int;
    sample_t               result;

    assign coef_in  = '{b0: b0, b1: b1, b2: b2, a1: a1, a2: a2};
    assign mac_last = (state == ST_MAC) && (idx == 3'd4);

    // Next state and handshake
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        accept    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_MAC;
                end
            end
            ST_MAC:  if (idx == 3'd4) state_nxt = ST_OUT;
            ST_OUT:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (reset) begin
            in_ready = 1'b0;
            accept   = 1'b0;
        end
    end

    // State register and tap counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                idx <= '0;
            else if (state == ST_MAC)
                idx <= idx + 3'd1;
        end
    end

    // Active/shadow coefficients: loads while busy wait until the sample retires
    always_ff @(posedge clk) begin
        if (reset) begin
            coef_act <= COEF_PASSTHRU;
            coef_shd <= COEF_PASSTHRU;
            pend     <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: if (coef_load) coef_act <= coef_in;
                ST_MAC: begin
                    if (coef_load) begin
                        coef_shd <= coef_in;
                        pend     <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (coef_load)
                        coef_act <= coef_in;
                    else if (pend)
                        coef_act <= coef_shd;
                    pend <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    biquad_mac #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .FRAC_BITS    (FRAC_BITS),
        .ACC_WIDTH    (ACC_WIDTH)
    ) u_mac (
        .clk     (clk),
        .reset   (reset),
        .start   (accept),
        .step    (state == ST_MAC),
        .idx     (idx),
        .coef    (coef_act),
        .x0      (x0),
        .x1      (x1),
        .x2      (x2),
        .y1      (y1),
        .y2      (y2),
        .acc_int (acc_int)
    );

`ifdef BIQUAD_SAT_EN
    localparam logic signed [AI-1:0] SAT_MAX = (AI'(1) <<< (SAMPLE_WIDTH - 1)) - AI'(1);
    localparam logic signed [AI-1:0] SAT_MIN = -(AI'(1) <<< (SAMPLE_WIDTH - 1));

    // Clamp the rounded result to the sample range
    always_comb begin
        result = acc_int[SAMPLE_WIDTH-1:0];
        if (acc_int > SAT_MAX)
            result = SAT_MAX[SAMPLE_WIDTH-1:0];
        else if (acc_int < SAT_MIN)
            result = SAT_MIN[SAMPLE_WIDTH-1:0];
    end
`else
    // Two's-complement wrap of the rounded result
    always_comb begin
        result = acc_int[SAMPLE_WIDTH-1:0];
    end
`endif

    // Output register (captured off the last tap so valid lands in the OUT cycle) and history
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_sample <= '0;
            x0 <= '0;
            x1 <= '0;
            x2 <= '0;
            y1 <= '0;
            y2 <= '0;
        end else begin
            out_valid <= 1'b0;
            if (accept)
                x0 <= in_sample;
            if (mac_last) begin
                out_sample <= result;
                out_valid  <= 1'b1;
            end
            if (state == ST_OUT) begin
                x2 <= x1;
                x1 <= x0;
                y2 <= y1;
                y1 <= out_sample;
            end
        end
    end

endmodule
